// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative RV32M multiply/divide unit beside the single-cycle ALU.
// Latency: DATA_WIDTH+2 edges counting the accept edge (34 at width 32); special cases 1 edge.
// Backpressure: holds out_valid/out_result in DONE until out_ready; in_ready low whenever busy.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   flush           kill the in-flight operation; no result is delivered
//   in_valid/ready  request handshake; in_op is one-hot
//                   [0]MUL [1]MULH [2]MULHSU [3]MULHU [4]DIV [5]DIVU [6]REM [7]REMU
//   in_src_1/2      rs1 (multiplicand/dividend), rs2 (multiplier/divisor)
//   out_valid/ready result handshake, out_result is registered
//   busy            high whenever the FSM is not IDLE
//
// Optional macro MULDIV_REUSE_EN: remember the last completed divide so a
// matching DIV/REM pair (same operands and signedness) finishes in one edge.
// Parameters: DATA_WIDTH even and >= 8; 2**CNT_WIDTH > DATA_WIDTH.

module alu_muldiv_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_src_1,
  input  logic [DATA_WIDTH-1:0] in_src_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  busy
);

  localparam int W  = DATA_WIDTH;
  localparam int W2 = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic [W-1:0] MIN_VAL  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES_VAL = {W{1'b1}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  // Multiply: {high partial sum, multiplier shifting out}.
  // Divide: low half holds dividend bits shifting out / quotient bits shifting in.
  logic [W2-1:0]        acc_q, acc_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [W-1:0]         opnd_q, opnd_d;
  // Partial remainder; always below the divisor so W bits suffice between steps.
  logic [W-1:0]         rem_q, rem_d;
  logic                 is_div_q, is_div_d;
  logic                 is_rem_q, is_rem_d;
  logic                 want_hi_q, want_hi_d;
  logic                 neg_q, neg_d;          // negate product / quotient in FIX
  logic                 rem_neg_q, rem_neg_d;  // remainder follows dividend sign
  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         result_q, result_d;

`ifdef MULDIV_REUSE_EN
  logic                 ru_vld_q, ru_vld_d;
  logic                 ru_signed_q, ru_signed_d;
  logic [W-1:0]         ru_src_1_q, ru_src_1_d;
  logic [W-1:0]         ru_src_2_q, ru_src_2_d;
  logic [W-1:0]         ru_quo_q, ru_quo_d;
  logic [W-1:0]         ru_rem_q, ru_rem_d;
  logic [W-1:0]         cur_src_1_q, cur_src_1_d;
  logic [W-1:0]         cur_src_2_q, cur_src_2_d;
  logic                 cur_signed_q, cur_signed_d;
`endif

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic         op_onehot;
  logic         in_is_mul, in_is_div, in_is_rem, in_want_hi;
  logic         in_s1_signed, in_s2_signed;
  logic         a_neg, b_neg;
  logic [W-1:0] a_abs, b_abs;

  always_comb begin
    op_onehot    = (in_op != 8'd0) && ((in_op & (in_op - 8'd1)) == 8'd0);
    in_is_mul    = |in_op[3:0];
    in_is_div    = |in_op[7:4];
    in_is_rem    = in_op[6] | in_op[7];
    in_want_hi   = |in_op[3:1];
    // MUL is treated as signed x signed: the low half is sign-agnostic.
    in_s1_signed = in_op[0] | in_op[1] | in_op[2] | in_op[4] | in_op[6];
    in_s2_signed = in_op[0] | in_op[1] | in_op[4] | in_op[6];
    a_neg        = in_s1_signed & in_src_1[W-1];
    b_neg        = in_s2_signed & in_src_2[W-1];
    a_abs        = a_neg ? (W'(0) - in_src_1) : in_src_1;
    b_abs        = b_neg ? (W'(0) - in_src_2) : in_src_2;
  end

  // ---------------------------------------------------------------------------
  // Special cases resolved in IDLE without iterating
  // ---------------------------------------------------------------------------
  logic         spec_hit;
  logic [W-1:0] spec_res;

  always_comb begin
    spec_hit = 1'b0;
    spec_res = '0;
    if (!op_onehot) begin
      spec_hit = 1'b1;
    end else if (in_is_mul && ((in_src_1 == '0) || (in_src_2 == '0))) begin
      spec_hit = 1'b1;
    end else if (in_is_div && (in_src_2 == '0)) begin
      spec_hit = 1'b1;
      spec_res = in_is_rem ? in_src_1 : ONES_VAL;
    end else if (in_is_div && in_s2_signed && (in_src_1 == MIN_VAL) && (in_src_2 == ONES_VAL)) begin
      spec_hit = 1'b1;
      spec_res = in_is_rem ? '0 : MIN_VAL;
`ifdef MULDIV_REUSE_EN
    end else if (in_is_div && ru_vld_q && (in_src_1 == ru_src_1_q) &&
                 (in_src_2 == ru_src_2_q) && (in_s2_signed == ru_signed_q)) begin
      spec_hit = 1'b1;
      spec_res = in_is_rem ? ru_rem_q : ru_quo_q;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration step and final sign fix-up
  // ---------------------------------------------------------------------------
  logic [W:0]    mul_sum;
  logic [W:0]    div_shift;   // W+1-bit partial remainder before trial subtract
  logic          div_take;
  logic [W2-1:0] prod_fix;
  logic [W-1:0]  quo_fix, rem_fix, fix_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    div_shift = {rem_q, acc_q[W-1]};
    div_take  = (div_shift >= {1'b0, opnd_q});
    prod_fix  = neg_q ? (W2'(0) - acc_q) : acc_q;
    quo_fix   = neg_q ? (W'(0) - acc_q[W-1:0]) : acc_q[W-1:0];
    rem_fix   = rem_neg_q ? (W'(0) - rem_q) : rem_q;
    if (is_div_q) begin
      fix_res = is_rem_q ? rem_fix : quo_fix;
    end else begin
      fix_res = want_hi_q ? prod_fix[W2-1:W] : prod_fix[W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    rem_d       = rem_q;
    is_div_d    = is_div_q;
    is_rem_d    = is_rem_q;
    want_hi_d   = want_hi_q;
    neg_d       = neg_q;
    rem_neg_d   = rem_neg_q;
    result_d    = result_q;
`ifdef MULDIV_REUSE_EN
    ru_vld_d     = ru_vld_q;
    ru_signed_d  = ru_signed_q;
    ru_src_1_d   = ru_src_1_q;
    ru_src_2_d   = ru_src_2_q;
    ru_quo_d     = ru_quo_q;
    ru_rem_d     = ru_rem_q;
    cur_src_1_d  = cur_src_1_q;
    cur_src_2_d  = cur_src_2_q;
    cur_signed_d = cur_signed_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          is_div_d  = in_is_div;
          is_rem_d  = in_is_rem;
          want_hi_d = in_want_hi;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
`ifdef MULDIV_REUSE_EN
          cur_src_1_d  = in_src_1;
          cur_src_2_d  = in_src_2;
          cur_signed_d = in_s2_signed;
`endif
          if (spec_hit) begin
            state_d  = S_DONE;
            result_d = spec_res;
`ifdef MULDIV_REUSE_EN
            if (op_onehot && in_is_mul) begin
              ru_vld_d = 1'b0;
            end
`endif
          end else begin
            state_d = S_CALC;
            cnt_d   = '0;
            rem_d   = '0;
            if (in_is_div) begin
              acc_d  = {{W{1'b0}}, a_abs};
              opnd_d = b_abs;
            end else begin
              acc_d  = {{W{1'b0}}, b_abs};
              opnd_d = a_abs;
            end
          end
        end
      end

      S_CALC: begin
        if (is_div_q) begin
          // Restoring step: keep the difference only when it does not go negative.
          rem_d = div_take ? W'(div_shift - {1'b0, opnd_q}) : div_shift[W-1:0];
          acc_d = {acc_q[W2-1:W], acc_q[W-2:0], div_take};
        end else begin
          // Shift-add step: add multiplicand on a set multiplier bit, shift right.
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_WIDTH'(W - 1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
`ifdef MULDIV_REUSE_EN
        if (is_div_q) begin
          ru_vld_d    = 1'b1;
          ru_signed_d = cur_signed_q;
          ru_src_1_d  = cur_src_1_q;
          ru_src_2_d  = cur_src_2_q;
          ru_quo_d    = quo_fix;
          ru_rem_d    = rem_fix;
        end else begin
          ru_vld_d = 1'b0;
        end
`endif
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything, including a same-cycle accept or out_ready.
    if (flush) begin
      state_d = S_IDLE;
`ifdef MULDIV_REUSE_EN
      if ((state_q != S_IDLE) && is_div_q) begin
        ru_vld_d = 1'b0;
      end
`endif
    end

    out_valid_d = (state_d == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      rem_q       <= '0;
      is_div_q    <= 1'b0;
      is_rem_q    <= 1'b0;
      want_hi_q   <= 1'b0;
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
`ifdef MULDIV_REUSE_EN
      ru_vld_q     <= 1'b0;
      ru_signed_q  <= 1'b0;
      ru_src_1_q   <= '0;
      ru_src_2_q   <= '0;
      ru_quo_q     <= '0;
      ru_rem_q     <= '0;
      cur_src_1_q  <= '0;
      cur_src_2_q  <= '0;
      cur_signed_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      rem_q       <= rem_d;
      is_div_q    <= is_div_d;
      is_rem_q    <= is_rem_d;
      want_hi_q   <= want_hi_d;
      neg_q       <= neg_d;
      rem_neg_q   <= rem_neg_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
`ifdef MULDIV_REUSE_EN
      ru_vld_q     <= ru_vld_d;
      ru_signed_q  <= ru_signed_d;
      ru_src_1_q   <= ru_src_1_d;
      ru_src_2_q   <= ru_src_2_d;
      ru_quo_q     <= ru_quo_d;
      ru_rem_q     <= ru_rem_d;
      cur_src_1_q  <= cur_src_1_d;
      cur_src_2_q  <= cur_src_2_d;
      cur_signed_q <= cur_signed_d;
`endif
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = result_q;

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// tb_alu_muldiv_iter: directed self-checking bench for alu_muldiv_iter (width 32).
// Latency is counted in rising edges with the accept edge as edge 1, so a
// special-case result reads 1 and a full iteration reads 34.

module tb_alu_muldiv_iter;

  localparam logic [7:0] OP_MUL    = 8'b0000_0001;
  localparam logic [7:0] OP_MULH   = 8'b0000_0010;
  localparam logic [7:0] OP_MULHSU = 8'b0000_0100;
  localparam logic [7:0] OP_MULHU  = 8'b0000_1000;
  localparam logic [7:0] OP_DIV    = 8'b0001_0000;
  localparam logic [7:0] OP_DIVU   = 8'b0010_0000;
  localparam logic [7:0] OP_REM    = 8'b0100_0000;
  localparam logic [7:0] OP_REMU   = 8'b1000_0000;

`ifdef MULDIV_REUSE_EN
  localparam int REM_AFTER_DIV_LAT = 1;
`else
  localparam int REM_AFTER_DIV_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_op;
  logic [31:0] in_src_1;
  logic [31:0] in_src_2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_muldiv_iter #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src_1   (in_src_1),
    .in_src_2   (in_src_2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for out_valid. When out_ready is high
  // the result is consumed before returning, leaving the unit in IDLE.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    in_op    = op;
    in_src_1 = a;
    in_src_2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = out_result;
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] res;
  logic [31:0] held;
  int          lat;
  int          seen;

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 8'd0;
    in_src_1  = '0;
    in_src_2  = '0;
    out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", out_result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Unsigned high / low product of all-ones
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    check("mulhu_res", res, 32'hFFFF_FFFE);
    check("mulhu_lat", 32'(lat), 32'd34);
    check("mulhu_idle_after", 32'(in_ready), 32'd1);
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    check("mul_res", res, 32'h0000_0001);
    check("mul_lat", 32'(lat), 32'd34);
    run_op(OP_MUL, 32'hFFFF_FFFD, 32'd5, res, lat);
    check("mul_neg_res", res, 32'hFFFF_FFF1);

    // Signed divide then remainder of the same operands
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, res, lat);
    check("div_res", res, 32'hFFFF_FFFD);
    check("div_lat", 32'(lat), 32'd34);
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, res, lat);
    check("rem_res", res, 32'hFFFF_FFFF);
    check("rem_lat", 32'(lat), 32'(REM_AFTER_DIV_LAT));

    // Special cases: one edge each
    run_op(OP_DIVU, 32'd5, 32'd0, res, lat);
    check("divu_by0_res", res, 32'hFFFF_FFFF);
    check("divu_by0_lat", 32'(lat), 32'd1);
    run_op(OP_REMU, 32'd9, 32'd0, res, lat);
    check("remu_by0_res", res, 32'd9);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    check("rem_ovf_res", res, 32'h0);
    check("rem_ovf_lat", 32'(lat), 32'd1);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    check("div_ovf_res", res, 32'h8000_0000);
    check("div_ovf_lat", 32'(lat), 32'd1);
    run_op(OP_MULH, 32'd0, 32'd5, res, lat);
    check("mul_zero_res", res, 32'h0);
    check("mul_zero_lat", 32'(lat), 32'd1);
    run_op(8'b0000_0011, 32'd7, 32'd5, res, lat);
    check("bad_op_res", res, 32'h0);
    check("bad_op_lat", 32'(lat), 32'd1);

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    run_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, res, lat);
    check("mulh_res", res, 32'h4000_0000);
    held = res;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", out_result, held);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);

    // Flush at CALC iteration 10
    @(negedge clk);
    in_op    = OP_DIVU;
    in_src_1 = 32'd100;
    in_src_2 = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("flush_busy_before", 32'(busy), 32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    check("flush_no_result", 32'(seen), 32'd0);
    run_op(OP_DIVU, 32'd100, 32'd3, res, lat);
    check("divu_res", res, 32'h0000_0021);
    check("divu_lat", 32'(lat), 32'd34);
    run_op(OP_REMU, 32'd100, 32'd3, res, lat);
    check("remu_res", res, 32'd1);

    // Flush in the same cycle as an accept drops the request
    @(negedge clk);
    in_op    = OP_DIVU;
    in_src_1 = 32'd50;
    in_src_2 = 32'd7;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_accept_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-MUL
    @(negedge clk);
    in_op    = OP_MUL;
    in_src_1 = 32'd3;
    in_src_2 = 32'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    check("arst_no_result", 32'(seen), 32'd0);
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, res, lat);
    check("mulhsu_res", res, 32'hFFFF_FFFF);
    check("mulhsu_lat", 32'(lat), 32'd34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
